// File: rtl/univ_shift_reg_if.sv
// Bus interface for univ_shift_reg: control, data and serial inputs from the
// master; register contents, serial outputs and burst status from the slave.
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, sin_l, sin_r, start, cnt,
    input  q, qbar, sout_l, sout_r, busy, done
  );

  modport slave (
    input  en, mode, d, sin_l, sin_r, start, cnt,
    output q, qbar, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with hold/load/shift/rotate modes,
// synchronous clear and an autonomous burst FSM performing cnt shifts.
// Optional feature: define ASR_EN to make mode 6 an arithmetic right shift;
// otherwise mode 6 holds and a burst request with mode 6 is a null burst.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  univ_shift_reg_if.slave    bus
);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_LOAD = 3'd1,
    M_SHL  = 3'd2,
    M_SHR  = 3'd3,
    M_ROTL = 3'd4,
    M_ROTR = 3'd5,
    M_ASR  = 3'd6,
    M_RSVD = 3'd7
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  mode_t            bmode_q, bmode_d;
  logic             done_q, done_d;
  mode_t            mode_in;

  assign mode_in = mode_t'(bus.mode);

  function automatic logic [WIDTH-1:0] apply_op(
    input mode_t            op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    apply_op = cur;
    case (op)
      M_LOAD: apply_op = ld;
      M_SHL:  apply_op = {cur[WIDTH-2:0], sl};
      M_SHR:  apply_op = {sr, cur[WIDTH-1:1]};
      M_ROTL: apply_op = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR: apply_op = {cur[0], cur[WIDTH-1:1]};
`ifdef ASR_EN
      M_ASR:  apply_op = {cur[WIDTH-1], cur[WIDTH-1:1]};
`else
      M_ASR:  apply_op = cur;
`endif
      default: apply_op = cur;
    endcase
  endfunction

  function automatic logic is_shift(input mode_t m);
    is_shift = 1'b0;
    case (m)
      M_SHL, M_SHR, M_ROTL, M_ROTR: is_shift = 1'b1;
`ifdef ASR_EN
      M_ASR: is_shift = 1'b1;
`endif
      default: is_shift = 1'b0;
    endcase
  endfunction

  // State register: clear aborts any burst without a done pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      bmode_q <= M_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      bmode_q <= bmode_d;
      done_q  <= done_d;
    end
  end

  // Next state: start in IDLE wins over direct mode and does not need en
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    bmode_d = bmode_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if ((bus.cnt != '0) && is_shift(mode_in)) begin
            bmode_d = mode_in;
            rem_d   = bus.cnt;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.en) begin
          q_d = apply_op(mode_in, q_q, bus.d, bus.sin_l, bus.sin_r);
        end
      end
      S_RUN: begin
        if (bus.en) begin
          q_d   = apply_op(bmode_q, q_q, bus.d, bus.sin_l, bus.sin_r);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: all derived combinationally from registered state
  always_comb begin
    bus.q      = q_q;
    bus.qbar   = ~q_q;
    bus.sout_l = q_q[WIDTH-1];
    bus.sout_r = q_q[0];
    bus.busy   = (state_q == S_RUN);
    bus.done   = done_q;
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  logic clk;
  logic clr;
  int   n_tests;
  int   n_fail;

  exp_t sb[$];

  // reference model: pending burst shifts held as a queue of mode codes
  logic [W-1:0] mq;
  int           pend[$];
  logic         mdone;

  univ_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_op(input int m, input logic [W-1:0] cur,
                                            input logic [W-1:0] ld, input logic sl, input logic sr);
    logic [W-1:0] msb;
    msb = {1'b1, {(W-1){1'b0}}};
    case (m)
      1: return ld;
      2: return (cur << 1) | W'(sl);
      3: return (cur >> 1) | (sr ? msb : '0);
      4: return (cur << 1) | (cur >> (W - 1));
      5: return (cur >> 1) | (cur << (W - 1));
`ifdef ASR_EN
      6: return (cur >> 1) | (cur & msb);
`endif
      default: return cur;
    endcase
  endfunction

  function automatic bit model_shiftable(input int m);
`ifdef ASR_EN
    return (m >= 2) && (m <= 6);
`else
    return (m >= 2) && (m <= 5);
`endif
  endfunction

  task automatic drive(input logic c, input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                       input logic sl, input logic sr, input logic st, input logic [CW-1:0] cn);
    exp_t ex;
    logic nd;
    @(negedge clk);
    clr       = c;
    bus.en    = e;
    bus.mode  = m;
    bus.d     = dd;
    bus.sin_l = sl;
    bus.sin_r = sr;
    bus.start = st;
    bus.cnt   = cn;
    if (c) begin
      mq    = '0;
      pend.delete();
      mdone = 1'b0;
    end else begin
      nd = 1'b0;
      if (pend.size() != 0) begin
        if (e) begin
          mq = model_op(pend.pop_front(), mq, dd, sl, sr);
          if (pend.size() == 0) nd = 1'b1;
        end
      end else if (st) begin
        if (cn != '0 && model_shiftable(int'(m))) begin
          for (int i = 0; i < int'(cn); i++) pend.push_back(int'(m));
        end else begin
          nd = 1'b1;
        end
      end else if (e) begin
        mq = model_op(int'(m), mq, dd, sl, sr);
      end
      mdone = nd;
    end
    ex.q    = mq;
    ex.busy = (pend.size() != 0);
    ex.done = mdone;
    sb.push_back(ex);
  endtask

  task automatic idle(input logic e);
    drive(1'b0, e, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // constant spot check of q right after the edge applying the last drive
  task automatic check_q(input string name, input logic [W-1:0] want);
    @(posedge clk);
    #2;
    n_tests++;
    if (bus.q !== want) begin
      n_fail++;
      $display("FAIL %s: q=%h expected %h", name, bus.q, want);
    end
  endtask

  // monitor: pops one expectation per clock edge and compares all outputs
  always @(posedge clk) begin
    exp_t ex;
    #1;
    if (sb.size() != 0) begin
      ex = sb.pop_front();
      n_tests++;
      if (bus.q !== ex.q) begin
        n_fail++;
        $display("FAIL sb_q @%0t: got %h expected %h", $time, bus.q, ex.q);
      end
      n_tests++;
      if (bus.qbar !== ~ex.q) begin
        n_fail++;
        $display("FAIL sb_qbar @%0t: got %h expected %h", $time, bus.qbar, ~ex.q);
      end
      n_tests++;
      if ({bus.sout_l, bus.sout_r} !== {ex.q[W-1], ex.q[0]}) begin
        n_fail++;
        $display("FAIL sb_sout @%0t: got %b%b expected %b%b", $time, bus.sout_l, bus.sout_r,
                 ex.q[W-1], ex.q[0]);
      end
      n_tests++;
      if (bus.busy !== ex.busy) begin
        n_fail++;
        $display("FAIL sb_busy @%0t: got %b expected %b", $time, bus.busy, ex.busy);
      end
      n_tests++;
      if (bus.done !== ex.done) begin
        n_fail++;
        $display("FAIL sb_done @%0t: got %b expected %b", $time, bus.done, ex.done);
      end
    end
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    mq        = '0;
    mdone     = 1'b0;
    clr       = 1'b1;
    bus.en    = 1'b0;
    bus.mode  = 3'd0;
    bus.d     = '0;
    bus.sin_l = 1'b0;
    bus.sin_r = 1'b0;
    bus.start = 1'b0;
    bus.cnt   = '0;

    // reset from arbitrary contents
    drive(1'b0, 1'b1, 3'd1, 8'h5A, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 3'd1, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd3);
    check_q("reset", 8'h00);

    // direct modes
    drive(1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 3'd2, '0, 1'b1, 1'b0, 1'b0, '0);
    check_q("shl", 8'h4B);
    drive(1'b0, 1'b1, 3'd3, '0, 1'b1, 1'b0, 1'b0, '0);
    check_q("shr", 8'h25);
    drive(1'b0, 1'b1, 3'd5, '0, 1'b1, 1'b1, 1'b0, '0);
    check_q("rotr", 8'h92);
    drive(1'b0, 1'b1, 3'd7, 8'h11, 1'b1, 1'b1, 1'b0, '0);
    check_q("reserved_hold", 8'h92);

    // burst ROTL by 3
    drive(1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 3'd4, '0, 1'b0, 1'b0, 1'b1, 4'd3);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check_q("burst_rotl", 8'h0C);
    idle(1'b1);

    // same burst with en dropped two cycles mid-burst
    drive(1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 3'd4, '0, 1'b0, 1'b0, 1'b1, 4'd3);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    check_q("burst_stall", 8'h0C);

    // null bursts, including one issued in the cycle done is high
    drive(1'b0, 1'b1, 3'd2, '0, 1'b1, 1'b1, 1'b1, 4'd0);
    drive(1'b0, 1'b1, 3'd0, '0, 1'b1, 1'b1, 1'b1, 4'd5);
    check_q("null_burst", 8'h0C);
    idle(1'b1);

    // clear mid-burst: no done pulse afterwards
    drive(1'b0, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 3'd2, '0, 1'b0, 1'b0, 1'b1, 4'd5);
    idle(1'b1);
    idle(1'b1);
    drive(1'b1, 1'b1, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0);
    check_q("clr_mid_burst", 8'h00);
    idle(1'b1);
    idle(1'b1);

    // mode 6 direct
    drive(1'b0, 1'b1, 3'd1, 8'h90, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 3'd6, '0, 1'b0, 1'b0, 1'b0, '0);
`ifdef ASR_EN
    check_q("mode6", 8'hC8);
`else
    check_q("mode6", 8'h90);
`endif

    // long SHR burst past the width
    drive(1'b0, 1'b1, 3'd1, 8'h01, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 3'd3, '0, 1'b0, 1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 3'd0, '0, 1'b0, 1'b1, 1'b0, '0);
    check_q("burst_shr9", 8'hFF);
    idle(1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 4) != 0),
            3'($urandom_range(0, 7)),
            W'($urandom),
            1'($urandom),
            1'($urandom),
            ($urandom_range(0, 5) == 0),
            CW'($urandom));
    end

    idle(1'b1);
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
